// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module  : sr_cmd_gen
// Brief   : Debounced, arbitrated S/R command pulse generator for a gated SR
//           latch. Optional q_model register enabled by SR_CMD_GEN_QMODEL_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sr_cmd_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic q_model
);

  localparam int c_DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_PG_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_PGW    = $clog2(c_PG_MAX + 1);

  localparam logic [c_DBW-1:0] c_DB_LAST    = c_DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PGW-1:0] c_PULSE_LAST = c_PGW'(PULSE_CYCLES - 1);
  localparam logic [c_PGW-1:0] c_GAP_LAST   = c_PGW'(GAP_CYCLES - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SET_P = 2'd1;
  localparam logic [1:0] c_RST_P = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  logic [1:0] w_raw;
  logic [1:0] w_rise;
  logic [1:0] w_req;

  assign w_raw = {btn_reset, btn_set};

  // Channel 0 = set, channel 1 = reset.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_DBW-1:0]       r_cnt;
      logic                   r_db;
      logic                   r_db_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_db   <= 1'b0;
          r_db_d <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
          r_db_d <= r_db;
          if (r_sync[SYNC_STAGES-1] == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_db  <= r_sync[SYNC_STAGES-1];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_rise[g] = r_db & ~r_db_d;
    end
  endgenerate

  logic [1:0]       r_state;
  logic [c_PGW-1:0] r_cnt;
  logic [1:0]       r_pend;
  logic             r_s;
  logic             r_r;
  logic             r_conflict;
  logic [1:0]       w_arb_state;
  logic             w_arb_conf;
  logic             w_arb_fire;

  assign w_req = w_rise | r_pend;

  always_comb begin
    w_arb_state = c_IDLE;
    w_arb_conf  = 1'b0;
    case (w_req)
      2'b01:   w_arb_state = c_SET_P;
      2'b10:   w_arb_state = c_RST_P;
      2'b11:   w_arb_conf  = 1'b1;
      default: w_arb_state = c_IDLE;
    endcase
  end

  // The last GAP cycle arbitrates like IDLE, so a queued command follows
  // after exactly GAP_CYCLES quiet cycles.
  assign w_arb_fire = (r_state == c_IDLE) ||
                      ((r_state == c_GAP) && (r_cnt == c_GAP_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= (r_state == c_SET_P);
      r_r        <= (r_state == c_RST_P);
      r_conflict <= 1'b0;
      if (w_arb_fire) begin
        r_state    <= w_arb_state;
        r_cnt      <= '0;
        r_pend     <= '0;
        r_conflict <= w_arb_conf;
      end else begin
        r_pend <= r_pend | w_rise;
        case (r_state)
          c_SET_P, c_RST_P: begin
            if (r_cnt == c_PULSE_LAST) begin
              r_state <= c_GAP;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          c_GAP:   r_cnt   <= r_cnt + 1'b1;
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = (r_state != c_IDLE);
  assign conflict = r_conflict;

`ifdef SR_CMD_GEN_QMODEL_EN
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (w_arb_fire && (w_arb_state == c_SET_P)) begin
      r_q <= 1'b1;
    end else if (w_arb_fire && (w_arb_state == c_RST_P)) begin
      r_q <= 1'b0;
    end
  end

  assign q_model = r_q;
`else
  assign q_model = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_sr_cmd_gen
// Brief   : Directed self-checking bench for sr_cmd_gen (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sr_cmd_gen;

`ifdef SR_CMD_GEN_QMODEL_EN
  localparam logic c_QEN = 1'b1;
`else
  localparam logic c_QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_set = 1'b0;
  logic btn_reset = 1'b0;
  wire  S, R, busy, conflict, q_model;

  always #5 clk = ~clk;

  sr_cmd_gen dut (
    .clk       (clk),
    .rst       (rst),
    .btn_set   (btn_set),
    .btn_reset (btn_reset),
    .S         (S),
    .R         (R),
    .busy      (busy),
    .conflict  (conflict),
    .q_model   (q_model)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Event counters sampled shortly after each rising edge.
  int   s_rise = 0, r_rise = 0, both_cyc = 0, busy_cyc = 0, conf_cyc = 0;
  logic s_prev = 1'b0, r_prev = 1'b0;

  always @(posedge clk) begin
    #2;
    if (S && !s_prev) s_rise++;
    if (R && !r_prev) r_rise++;
    if (S && R) both_cyc++;
    if (busy) busy_cyc++;
    if (conflict) conf_cyc++;
    s_prev = S;
    r_prev = R;
  end

  int b_s, b_r, b_busy, b_conf;

  task automatic snap();
    b_s    = s_rise;
    b_r    = r_rise;
    b_busy = busy_cyc;
    b_conf = conf_cyc;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  initial begin
    // Reset held with btn_set pressed.
    #1 rst = 1'b1;
    btn_set = 1'b1;
    negs(3);
    chk("rst_S", S, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    chk("rst_q", q_model, 1'b0);
    snap();
    rst = 1'b0;
    negs(7);
    chk("t1_S_edge6", S, 1'b0);
    chk("t1_busy_edge6", busy, 1'b1);
    negs(1);
    chk("t1_S_edge7", S, 1'b1);
    negs(1);
    chk("t1_S_edge8", S, 1'b1);
    negs(1);
    chk("t1_S_edge9", S, 1'b0);
    chk("t1_busy_edge9", busy, 1'b0);
    negs(10);
    btn_set = 1'b0;
    negs(20);
    chk("t1_hold_one_pulse", s_rise - b_s, 1);

    // Normal set then reset.
    snap();
    btn_set = 1'b1;
    negs(20);
    chk("t2_q_after_set", q_model, c_QEN);
    btn_set = 1'b0;
    negs(20);
    btn_reset = 1'b1;
    negs(7);
    chk("t2_R_edge6", R, 1'b0);
    negs(1);
    chk("t2_R_edge7", R, 1'b1);
    chk("t2_S_during_R", S, 1'b0);
    chk("t2_q_after_rst", q_model, 1'b0);
    negs(1);
    chk("t2_R_edge8", R, 1'b1);
    negs(1);
    chk("t2_R_edge9", R, 1'b0);
    negs(17);
    btn_reset = 1'b0;
    negs(20);
    chk("t2_s_pulses", s_rise - b_s, 1);
    chk("t2_r_pulses", r_rise - b_r, 1);
    chk("t2_conflicts", conf_cyc - b_conf, 0);

    // Glitch of 3 cycles is rejected.
    snap();
    btn_set = 1'b1;
    negs(3);
    btn_set = 1'b0;
    negs(15);
    chk("t3_glitch_s_pulses", s_rise - b_s, 0);
    chk("t3_glitch_busy", busy_cyc - b_busy, 0);

    // Exactly 4 cycles is accepted.
    snap();
    btn_set = 1'b1;
    negs(4);
    btn_set = 1'b0;
    negs(20);
    chk("t3_min_press_s_pulses", s_rise - b_s, 1);

    // Simultaneous press.
    snap();
    btn_set = 1'b1;
    btn_reset = 1'b1;
    negs(6);
    chk("t4_conflict_edge5", conflict, 1'b0);
    negs(1);
    chk("t4_conflict_edge6", conflict, 1'b1);
    negs(1);
    chk("t4_conflict_edge7", conflict, 1'b0);
    negs(12);
    btn_set = 1'b0;
    btn_reset = 1'b0;
    negs(20);
    chk("t4_conflict_cycles", conf_cyc - b_conf, 1);
    chk("t4_s_pulses", s_rise - b_s, 0);
    chk("t4_r_pulses", r_rise - b_r, 0);
    chk("t4_busy", busy_cyc - b_busy, 0);

    // Reset request queued behind a set pulse.
    snap();
    btn_set = 1'b1;
    negs(1);
    btn_reset = 1'b1;
    negs(7);
    chk("t5_S_edge7", S, 1'b1);
    chk("t5_R_edge7", R, 1'b0);
    negs(1);
    chk("t5_S_edge8", S, 1'b1);
    negs(1);
    chk("t5_S_gap", S, 1'b0);
    chk("t5_R_gap", R, 1'b0);
    chk("t5_busy_gap", busy, 1'b1);
    negs(1);
    chk("t5_R_edge10", R, 1'b1);
    chk("t5_S_edge10", S, 1'b0);
    negs(1);
    chk("t5_R_edge11", R, 1'b1);
    negs(1);
    chk("t5_R_edge12", R, 1'b0);
    chk("t5_busy_edge12", busy, 1'b0);
    negs(10);
    btn_set = 1'b0;
    btn_reset = 1'b0;
    negs(20);
    chk("t5_s_pulses", s_rise - b_s, 1);
    chk("t5_r_pulses", r_rise - b_r, 1);
    chk("t5_conflicts", conf_cyc - b_conf, 0);

    // Reset during the second R cycle with a set request pending.
    snap();
    btn_reset = 1'b1;
    negs(1);
    btn_set = 1'b1;
    negs(8);
    chk("t6_R_before_rst", R, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_R_async_drop", R, 1'b0);
    chk("t6_S_async", S, 1'b0);
    chk("t6_busy_async", busy, 1'b0);
    btn_set = 1'b0;
    btn_reset = 1'b0;
    negs(3);
    rst = 1'b0;
    negs(25);
    chk("t6_s_pulses", s_rise - b_s, 0);
    chk("t6_r_pulses", r_rise - b_r, 1);

    chk("never_S_and_R", both_cyc, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the gated SR latch (`part1`): converts two raw pushbutton inputs into clean, timed S and R command pulses.
- Per-channel synchroniser and debouncer feed a small arbitration FSM.
- The FSM guarantees S and R are never asserted together, so the latch's forbidden R=S=1 input can never occur.
- S/R outputs connect directly to the latch's S/R inputs on the same clk.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per raw input synchroniser (≥2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the debounced level before that level updates (≥1).
- PULSE_CYCLES, 2, cycles S or R is held high per command (≥1).
- GAP_CYCLES, 1, cycles both outputs are forced low after each pulse (≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- btn_set  input  1  raw set button, asynchronous to clk, active-high.
- btn_reset  input  1  raw reset button, asynchronous to clk, active-high.
- S  output  1  set command to latch.
- R  output  1  reset command to latch.
- busy  output  1  high in any FSM state other than IDLE.
- conflict  output  1  one-cycle pulse when a set/reset collision is dropped.
- q_model  output  1  expected latch state (see Optional Feature).

Behaviour:
- Reset: one clock, asynchronous, active-high. While rst=1, all outputs are 0, synchronisers and debounced levels are 0, counters are 0, pending bits are clear, and the FSM is in IDLE.
- Synchroniser: SYNC_STAGES flops per channel. No combinational path from btn_* to any output.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == db: cnt <= 0.
  - sync != db and cnt == DEBOUNCE_CYCLES-1: db <= sync, cnt <= 0.
  - Otherwise cnt++.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect: rise_x = db_x & ~db_x_d, a one-cycle pulse. Falling edges generate nothing.
- FSM states: IDLE, SET_P, RST_P, GAP. Pulse/gap counter width is $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1).
- IDLE, with request = rise_x OR pending_x:
  - Set only: SET_P.
  - Reset only: RST_P.
  - Both in the same cycle: stay in IDLE, drop both, clear pending, conflict=1 for one cycle.
- SET_P / RST_P: S (resp. R) is 1 for exactly PULSE_CYCLES cycles, then GAP.
- GAP: S=R=0 for GAP_CYCLES cycles, then IDLE.
- Rise while not IDLE: sets pending_x (one deep). A second rise on the same channel while pending is already set is absorbed. Pending requests are served through the IDLE rules above.
- Outputs: S and R are registered outputs of the FSM. S & R == 1 never occurs in any state.
- Latency: a btn_set rise stable before clk edge k gives S=1 from edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1 (7 with defaults).
- Holding a button produces exactly one pulse. Release, debounced, then re-press produces another.
- Reset mid-pulse: S/R drop immediately. A button still held at rst deassertion is re-synchronised and re-debounced from db=0, so it produces one new pulse.

Optional Feature:
- Macro: SR_CMD_GEN_QMODEL_EN.
- Defined: q_model is a register, reset 0. It is set to 1 on the first cycle of SET_P and cleared to 0 on the first cycle of RST_P; otherwise it holds. It equals the latch Q one cycle after each pulse starts, for bench cross-checking.
- Undefined: q_model is tied to constant 0 and no register is synthesised. The port list is unchanged.

Test Plan:
- Reset behaviour: assert rst with btn_set=1 for 3 cycles, then release → S=R=busy=conflict=0 during reset; after release, S rises exactly 7 edges later and stays high 2 cycles.
- Normal set/reset: btn_set high 20 cycles, then low 20 cycles, then btn_reset high 20 cycles → one S pulse (2 cycles), then 1 gap cycle; later one R pulse (2 cycles); S&R never 1; q_model (macro on) goes 1 then 0.
- Glitch rejection: btn_set high for 3 cycles (< DEBOUNCE_CYCLES) → S stays 0 and busy stays 0.
- Simultaneous press: btn_set and btn_reset rise on the same edge → conflict=1 for exactly one cycle; S=R=0 throughout; busy stays 0.
- Pending request: btn_reset rises 1 cycle after an S pulse begins → S for 2 cycles, gap 1 cycle, then R for 2 cycles; no conflict.
- Reset mid-operation: assert rst on the second cycle of an R pulse → R drops asynchronously within the same cycle; pending cleared; no pulse after release unless a button is still held.
